// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one execute-unit result per
// cycle and holds it in a registered broadcast stage until the ROB takes it.
module cdb_arbiter #(
    parameter int N_REQ  = 5,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_grant,
    input  logic                      cdb_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [2:0]                cdb_src
);
    localparam int PTR_W = $clog2(N_REQ);

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic [2:0]        r_src;
    logic [PTR_W-1:0]  r_last;

    logic              w_open;
    logic              w_found;
    logic              w_grant;
    logic [PTR_W-1:0]  w_sel;
    logic [PTR_W-1:0]  w_idx;

    // Scan starting just after the last winner, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PTR_W'((int'(r_last) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_open    = ~r_valid | cdb_ready;
    assign w_grant   = w_open & ~flush & ~rst & w_found;
    assign req_grant = w_grant ? (N_REQ'(1) << w_sel) : '0;

    // Flush only drops valid; tag/data are don't-care once the stage is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
            r_src   <= '0;
            r_last  <= PTR_W'(N_REQ - 1);
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_tag   <= req_tag[int'(w_sel)*TAG_W +: TAG_W];
            r_data  <= req_data[int'(w_sel)*DATA_W +: DATA_W];
            r_src   <= 3'(w_sel);
            r_last  <= w_sel;
        end else if (cdb_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign cdb_valid = r_valid;
    assign cdb_tag   = r_tag;
    assign cdb_data  = r_data;
    assign cdb_src   = r_src;
endmodule
